// File: rtl/frame_fifo_ctrl.sv
// Frame-committing FIFO controller that drives both ports of an external dual-port trace RAM.
// Words become readable only once a whole frame of FRAME_LEN words has been written; a partial frame can be abandoned.
module frame_fifo_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_LEN  = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  abort,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   frames_avail,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam int PW  = ADDR_WIDTH + 1;
  localparam int WCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  localparam logic [PW-1:0]  CAPACITY    = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [PW-1:0]  PTR_ONE     = PW'(1);
  localparam logic [PW-1:0]  FRAME_LEN_P = PW'(FRAME_LEN);
  localparam logic [WCW-1:0] WCNT_ONE    = WCW'(1);
  localparam logic [WCW-1:0] WCNT_LAST   = WCW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2
  } rd_state_e;

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [WCW-1:0]        wcnt_q, wcnt_d;
  logic [PW-1:0]         frames_avail_q, frames_avail_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  rd_state_e             state_q, state_d;

  logic [PW-1:0] used_words;
  logic [PW-1:0] committed_words;
  logic          full;
  logic          accept;

  assign used_words      = wr_ptr_q - rd_ptr_q;
  assign committed_words = commit_ptr_q - rd_ptr_q;
  assign full            = (used_words == CAPACITY);
  // Gating with rstn keeps the RAM untouched during a reset cycle.
  assign accept          = in_valid & ~full & ~abort & rstn;

  assign in_ready     = ~full;
  assign ram_we       = accept;
  assign ram_waddr    = wr_ptr_q[ADDR_WIDTH-1:0];
  assign ram_din      = in_data;
  assign ram_raddr    = rd_ptr_q[ADDR_WIDTH-1:0];
  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign frames_avail = frames_avail_q;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    wcnt_d       = wcnt_q;
    if (abort) begin
      wr_ptr_d = commit_ptr_q;
      wcnt_d   = '0;
    end else if (accept) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (wcnt_q == WCNT_LAST) begin
        wcnt_d       = '0;
        commit_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wcnt_d = wcnt_q + WCNT_ONE;
      end
    end
  end

  assign frames_avail_d = committed_words / FRAME_LEN_P;

  // The read address always tracks rd_ptr, so by the end of EMPTY the RAM has already latched the head word.
  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_EMPTY: begin
        out_valid_d = 1'b0;
        if (commit_ptr_q != rd_ptr_q) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        out_data_d  = ram_dout;
        out_valid_d = 1'b1;
        state_d     = S_VALID;
      end
      S_VALID: begin
        if (out_ready) begin
          rd_ptr_d    = rd_ptr_q + PTR_ONE;
          out_valid_d = 1'b0;
          state_d     = S_EMPTY;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q       <= '0;
      commit_ptr_q   <= '0;
      rd_ptr_q       <= '0;
      wcnt_q         <= '0;
      frames_avail_q <= '0;
      out_data_q     <= '0;
      out_valid_q    <= 1'b0;
      state_q        <= S_EMPTY;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      commit_ptr_q   <= commit_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      wcnt_q         <= wcnt_d;
      frames_avail_q <= frames_avail_d;
      out_data_q     <= out_data_d;
      out_valid_q    <= out_valid_d;
      state_q        <= state_d;
    end
  end

endmodule

// File: tb/tb_frame_fifo_ctrl.sv
// Randomised and directed bench for frame_fifo_ctrl with a behavioural RAM and a queue-based frame model.
module tb_frame_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        abort;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  frames_avail;
  logic        ram_we;
  logic [3:0]  ram_waddr;
  logic [15:0] ram_din;
  logic [3:0]  ram_raddr;
  logic [15:0] ram_dout;

  logic [15:0] mem [16];

  frame_fifo_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .FRAME_LEN(4)) dut (
    .clk(clk), .rstn(rstn),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .abort(abort),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .frames_avail(frames_avail),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_din(ram_din),
    .ram_raddr(ram_raddr), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_din;
    ram_dout <= mem[ram_raddr];
  end

  // Model: cq holds committed, not-yet-popped words (head = word shown on out_data); pq holds the open frame.
  logic [15:0] cq [$];
  logic [15:0] pq [$];
  logic [15:0] popped [$];
  int          n_popped = 0;
  int          fa_m = 0;
  int          stall = 0;
  logic [3:0]  last_waddr = 4'd0;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check outputs, advance the model on the posedge using pre-edge values.
  task automatic cycle(input logic iv, input logic [15:0] d, input logic ab, input logic ordy, input logic rst);
    int   occ;
    logic acc;
    logic pop;
    in_valid = iv; in_data = d; abort = ab; out_ready = ordy; rstn = rst;
    #1;
    occ = cq.size() + pq.size();
    acc = rst && iv && !ab && (occ < 16);
    check("in_ready", 32'(in_ready), 32'(occ < 16));
    check("ram_we", 32'(ram_we), 32'(acc));
    if (acc) begin
      check("ram_waddr", 32'(ram_waddr), 32'((n_popped + occ) % 16));
      check("ram_din", 32'(ram_din), 32'(d));
      last_waddr = ram_waddr;
    end
    check("frames_avail", 32'(frames_avail), 32'(fa_m));
    if (out_valid) begin
      check("valid_has_data", 32'(cq.size() > 0), 32'd1);
      if (cq.size() > 0) check("out_data", 32'(out_data), 32'(cq[0]));
    end
    if (cq.size() > 0) begin
      if (!out_valid) stall++; else stall = 0;
      check("read_stall", 32'(stall <= 2), 32'd1);
    end else begin
      stall = 0;
    end
    pop = rst && out_valid && ordy;
    @(posedge clk);
    if (!rst) begin
      cq.delete(); pq.delete();
      n_popped = 0; fa_m = 0; stall = 0;
    end else begin
      fa_m = cq.size() / 4;
      if (pop && cq.size() > 0) begin
        $display("pop #%0d data=%04h", n_popped, cq[0]);
        popped.push_back(cq.pop_front());
        n_popped++;
      end
      if (ab) begin
        pq.delete();
      end else if (acc) begin
        pq.push_back(d);
        if (pq.size() == 4) begin
          while (pq.size() > 0) cq.push_back(pq.pop_front());
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (cq.size() == 0 && !out_valid) break;
      cycle(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
    end
    check("drain_empty", 32'(cq.size()), 32'd0);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 10; i++) begin
      if (out_valid) break;
      cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    end
    check(tag, 32'(out_valid), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    int hist;
    logic iv;
    in_valid = 0; in_data = 0; abort = 0; out_ready = 0; rstn = 0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1;

    // Reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_frames_avail", 32'(frames_avail), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);

    // First frame: nothing visible until the fourth word commits
    for (int i = 1; i <= 3; i++) begin
      cycle(1'b1, 16'(i), 1'b0, 1'b1, 1'b1);
      check("t1_fa_partial", 32'(frames_avail), 32'd0);
      check("t1_ov_partial", 32'(out_valid), 32'd0);
    end
    cycle(1'b1, 16'h0004, 1'b0, 1'b1, 1'b1);
    check("t1_ov_edge", 32'(out_valid), 32'd0);
    cycle(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
    check("t1_fa_commit", 32'(frames_avail), 32'd1);
    check("t1_ov_fetch", 32'(out_valid), 32'd0);
    cycle(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
    check("t1_ov_latency", 32'(out_valid), 32'd1);
    check("t1_first_word", 32'(out_data), 32'h0001);
    drain();

    // Fill to capacity with the reader stalled
    for (int i = 0; i < 16; i++) cycle(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0, 1'b1);
    check("t2_full", 32'(in_ready), 32'd0);
    cycle(1'b1, 16'h01FF, 1'b0, 1'b0, 1'b1);
    check("t2_fa_full", 32'(frames_avail), 32'd4);
    cycle(1'b1, 16'h01FF, 1'b0, 1'b0, 1'b1);
    check("t2_we_blocked", 32'(ram_we), 32'd0);
    wait_valid("t2_valid");
    cycle(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
    check("t2_space_freed", 32'(in_ready), 32'd1);
    drain();

    // Abort a two-word partial frame, then write a fresh frame over it
    base = (n_popped + cq.size()) % 16;
    hist = popped.size();
    cycle(1'b1, 16'h0055, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 16'h0066, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 16'h0077, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 16'h00A0, 1'b0, 1'b1, 1'b1);
    check("t3_rewind_addr", 32'(last_waddr), 32'(base));
    for (int i = 1; i < 4; i++) cycle(1'b1, 16'(16'h00A0 + i), 1'b0, 1'b1, 1'b1);
    drain();
    check("t3_count", 32'(popped.size() - hist), 32'd4);
    for (int i = 0; i < 4 && hist + i < popped.size(); i++)
      check("t3_readout", 32'(popped[hist + i]), 32'(16'h00A0 + i));

    // 40-word stream with random back-pressure, across pointer wrap
    hist = popped.size();
    n = 0;
    for (int c = 0; c < 2000 && n < 40; c++) begin
      iv = ($urandom_range(0, 3) != 0);
      if (iv && (cq.size() + pq.size() < 16)) n++;
      cycle(iv, 16'($urandom), 1'b0, 1'($urandom_range(0, 1)), 1'b1);
    end
    check("t4_sent", 32'(n), 32'd40);
    drain();
    check("t4_received", 32'(popped.size() - hist), 32'd40);

    // Random traffic including aborts
    for (int c = 0; c < 400; c++)
      cycle(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 11) == 0),
            1'($urandom_range(0, 1)), 1'b1);
    cycle(1'b0, 16'h0, 1'b1, 1'b1, 1'b1);
    drain();

    // Hold with out_ready low, then exactly one pop
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'(16'h0500 + i), 1'b0, 1'b0, 1'b1);
    wait_valid("t5_valid");
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      check("t5_hold_data", 32'(out_data), 32'h0500);
      check("t5_hold_valid", 32'(out_valid), 32'd1);
      check("t5_hold_fa", 32'(frames_avail), 32'd1);
    end
    cycle(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
    check("t5_popped_ov", 32'(out_valid), 32'd0);
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    check("t5_fa_after", 32'(frames_avail), 32'd0);
    wait_valid("t5_next_valid");
    check("t5_next_word", 32'(out_data), 32'h0501);
    drain();

    // Synchronous reset mid-frame while out_valid is high
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'(16'h0600 + i), 1'b0, 1'b0, 1'b1);
    wait_valid("t6_valid");
    cycle(1'b1, 16'h0700, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 16'h0701, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0; rstn = 1'b1;
    #1;
    check("t6_ov", 32'(out_valid), 32'd0);
    check("t6_fa", 32'(frames_avail), 32'd0);
    check("t6_in_ready", 32'(in_ready), 32'd1);
    check("t6_ram_we", 32'(ram_we), 32'd0);
    hist = popped.size();
    cycle(1'b1, 16'h0800, 1'b0, 1'b1, 1'b1);
    check("t6_waddr0", 32'(last_waddr), 32'd0);
    for (int i = 1; i < 4; i++) cycle(1'b1, 16'(16'h0800 + i), 1'b0, 1'b1, 1'b1);
    drain();
    check("t6_count", 32'(popped.size() - hist), 32'd4);
    for (int i = 0; i < 4 && hist + i < popped.size(); i++)
      check("t6_readout", 32'(popped[hist + i]), 32'(16'h0800 + i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
